// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters.
// Latches the winning byte, pulses tx_start, and waits for a tick-qualified tx_done_tick or a timeout.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DBIT-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     s_tick,
  input  logic                     tx_done_tick,
  output logic                     tx_start,
  output logic [DBIT-1:0]          tx_din,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int IDW       = $clog2(NREQ);
  localparam int MIN_TICKS = 16 * (DBIT + 1);
  localparam int MAX_TICKS = MIN_TICKS + SB_TICK + 16;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] MIN_C = TW'(MIN_TICKS);
  localparam logic [TW-1:0] MAX_C = TW'(MAX_TICKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [IDW-1:0]  last_r;
  logic [IDW-1:0]  grant_r;
  logic [TW-1:0]   tick_cnt_r;
  logic [TW-1:0]   tick_inc_s;
  logic [DBIT-1:0] tx_din_r;
  logic            busy_r;
  logic            tx_start_r;
  logic            err_r;
  logic [IDW:0]    pick_s;
  logic [DBIT-1:0] win_data_s;
  logic [NREQ-1:0] ready_s;
  logic            accept_s;
  logic            done_s;
  logic            timeout_s;

  // Returns {found, index}: first valid requester scanning last+1, last+2, ... modulo NREQ.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  last);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    res = {(IDW+1){1'b0}};
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (valid[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Winner selection and its byte.
  always_comb begin
    pick_s     = rr_pick(req_valid, last_r);
    win_data_s = {DBIT{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (pick_s[IDW-1:0] == IDW'(i)) begin
        win_data_s = req_data[i*DBIT +: DBIT];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Next-state, handshake and completion decode.
  always_comb begin
    state_s   = state_r;
    ready_s   = {NREQ{1'b0}};
    accept_s  = 1'b0;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    // A tick landing with tx_done_tick counts before qualification.
    if (s_tick && (tick_cnt_r != MAX_C)) begin
      tick_inc_s = tick_cnt_r + TW'(1);
    end else begin
      tick_inc_s = tick_cnt_r;
    end
    case (state_r)
      IDLE: begin
        if (pick_s[IDW] && !reset) begin
          ready_s[pick_s[IDW-1:0]] = 1'b1;
          accept_s                 = 1'b1;
          state_s                  = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: state_s = WAIT;
      WAIT: begin
        if (tx_done_tick && (tick_inc_s >= MIN_C)) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else if (tick_cnt_r == MAX_C) begin
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, grant, latched byte, tick counter and output pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      last_r     <= IDW'(NREQ - 1);
      grant_r    <= {IDW{1'b0}};
      tick_cnt_r <= {TW{1'b0}};
      tx_din_r   <= {DBIT{1'b0}};
      busy_r     <= 1'b0;
      tx_start_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      tx_start_r <= accept_s;
      err_r      <= timeout_s;
      if (accept_s) begin
        tx_din_r <= win_data_s;
        grant_r  <= pick_s[IDW-1:0];
        last_r   <= pick_s[IDW-1:0];
        busy_r   <= 1'b1;
      end else if (done_s || timeout_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
      if (state_r == START) begin
        tick_cnt_r <= {TW{1'b0}};
      end else if (state_r == WAIT) begin
        tick_cnt_r <= tick_inc_s;
      end else begin
        tick_cnt_r <= tick_cnt_r;
      end
    end
  end

  assign req_ready   = ready_s;
  assign tx_start    = tx_start_r;
  assign tx_din      = tx_din_r;
  assign grant_id    = grant_r;
  assign busy        = busy_r;
  assign err_timeout = err_r;

endmodule
